regfile_sb: RTL

- Parametrised successor to the fixed 32x32 MIPS register file for the multi-cycle CPU.
- Configurable width, depth and read-port count.
- Optional write-to-read bypass.
- Per-register busy scoreboard: a multi-cycle producer reserves its destination at issue and clears it at writeback, and the control FSM stalls on busy operands.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_busy_sb.sv | 77 +++++++
 rtl/regfile_sb.sv | 82 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the scoreboarded register file
package regfile_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_DEPTH   = 32;
  localparam int RESERVE_TIMEOUT = 64;
  localparam int WDOG_W          = 7;

  // Ceiling log2 for sizing address fields; returns at least 1.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_busy_sb.sv
// rtl/regfile_busy_sb.sv - per-register busy scoreboard with reserve handshake and conflict watchdog
module regfile_busy_sb import regfile_pkg::*; #(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic [AW-1:0]    write_addr,
  input  logic             reserve,
  input  logic [AW-1:0]    reserve_addr,
  output logic [DEPTH-1:0] busy,
  output logic             reserve_ack,
  output logic             conflict
);

  logic              armed;
  logic [WDOG_W-1:0] wdog;
  logic              reserve_zero;
  logic              write_zero;
  logic              unreserved_write;
  logic              wdog_expired;

  // Register 0 can never be reserved or tracked when it is hardwired.
  assign reserve_zero = (ZERO_REG != 0) && (reserve_addr == '0);
  assign write_zero   = (ZERO_REG != 0) && (write_addr == '0);

  // Ack looks at the pre-edge busy bit, so a register being cleared this cycle is not re-acked yet.
  assign reserve_ack = reserve && !busy[reserve_addr] && !reserve_zero;

  // Once the scoreboard is in use, a write to an untracked register indicates a broken producer.
  assign unreserved_write = armed && write_en && !write_zero && !busy[write_addr] &&
                            !(reserve_ack && (reserve_addr == write_addr));

  assign wdog_expired = reserve && !reserve_ack && (wdog >= WDOG_W'(RESERVE_TIMEOUT));

  // Busy bits: writeback clears, an accepted reservation sets (reservation wins on the same register).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (write_en)    busy[write_addr]   <= 1'b0;
      if (reserve_ack) busy[reserve_addr] <= 1'b1;
    end
  end

  // Watchdog counts consecutive unacknowledged reserve cycles, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= '0;
    end else if (!reserve || reserve_ack) begin
      wdog <= '0;
    end else if (wdog != '1) begin
      wdog <= wdog + 1'b1;
    end
  end

  // Unreserved-write checking only starts after the first accepted reservation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else if (reserve_ack) begin
      armed <= 1'b1;
    end
  end

  // Sticky debug flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict <= 1'b0;
    end else if (unreserved_write || wdog_expired) begin
      conflict <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with bypass and busy scoreboard
module regfile_sb import regfile_pkg::*; #(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NRD*AW-1:0]    ReadRegister,
  output logic [NRD*WIDTH-1:0] ReadData,
  output logic [NRD-1:0]       ReadBusy,
  input  logic [AW-1:0]        WriteRegister,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic                 RegWrite,
  input  logic                 Reserve,
  input  logic [AW-1:0]        ReserveRegister,
  output logic                 ReserveAck,
  output logic                 Conflict
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             write_zero;
  logic [AW-1:0]    rd_addr;
  logic             rd_zero;
  logic             rd_bypass;

  assign write_zero = (ZERO_REG != 0) && (WriteRegister == '0);

  regfile_busy_sb #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_busy (
    .clk          (Clk),
    .rst          (Reset),
    .write_en     (RegWrite),
    .write_addr   (WriteRegister),
    .reserve      (Reserve),
    .reserve_addr (ReserveRegister),
    .busy         (busy),
    .reserve_ack  (ReserveAck),
    .conflict     (Conflict)
  );

  // Storage: single write port, writes to the hardwired zero register are dropped.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (RegWrite && !write_zero) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  // Asynchronous read ports with optional same-cycle forwarding of the write port.
  always_comb begin
    ReadData  = '0;
    ReadBusy  = '0;
    rd_addr   = '0;
    rd_zero   = 1'b0;
    rd_bypass = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      rd_addr   = ReadRegister[k*AW +: AW];
      rd_zero   = (ZERO_REG != 0) && (rd_addr == '0);
      rd_bypass = (BYPASS != 0) && RegWrite && (WriteRegister == rd_addr) && !rd_zero;
      if (rd_zero) begin
        ReadData[k*WIDTH +: WIDTH] = '0;
        ReadBusy[k]                = 1'b0;
      end else if (rd_bypass) begin
        // Forwarded value is final unless a new producer claims the register this cycle.
        ReadData[k*WIDTH +: WIDTH] = WriteData;
        ReadBusy[k]                = ReserveAck && (ReserveRegister == rd_addr);
      end else begin
        ReadData[k*WIDTH +: WIDTH] = regs[rd_addr];
        ReadBusy[k]                = busy[rd_addr];
      end
    end
  end

endmodule
